// File: rtl/lcd_axi_rd_arb.sv
// Two-requester read-address arbiter for the LCD controller's AXI4 read master.
// S0 (frame DMA) has priority; S1 gets one forced grant after STREAK back-to-back S0 wins.
module lcd_axi_rd_arb #(
    parameter int          STREAK    = 4,
    parameter logic [2:0]  ARSIZE_V  = 3'd2,
    parameter logic [1:0]  ARBURST_V = 2'd1,
    parameter logic [3:0]  ARCACHE_V = 4'd3
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESETN,
    input  logic [31:0] S0_ARADDR,
    input  logic [7:0]  S0_ARLEN,
    input  logic        S0_ARVALID,
    output logic        S0_ARREADY,
    output logic        S0_RVALID,
    output logic        S0_RLAST,
    input  logic        S0_RREADY,
    input  logic [31:0] S1_ARADDR,
    input  logic [7:0]  S1_ARLEN,
    input  logic        S1_ARVALID,
    output logic        S1_ARREADY,
    output logic        S1_RVALID,
    output logic        S1_RLAST,
    input  logic        S1_RREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic [7:0]  M_AXI_ARLEN,
    output logic [2:0]  M_AXI_ARSIZE,
    output logic [1:0]  M_AXI_ARBURST,
    output logic [3:0]  M_AXI_ARCACHE,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic        M_AXI_RVALID,
    input  logic        M_AXI_RLAST,
    input  logic [1:0]  M_AXI_RRESP,
    output logic        M_AXI_RREADY,
    output logic        grant,
    output logic        busy,
    output logic        rd_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [7:0] STREAK_LIM = 8'(STREAK);

    state_t      state_reg;
    logic [7:0]  streak_reg;
    logic [31:0] araddr_reg;
    logic [7:0]  arlen_reg;
    logic        arvalid_reg;
    logic        grant_reg;
    logic        rd_err_reg;

    logic        pick_s1;
    logic        in_data;
    logic        owner_rready;
    logic        beat_ok;

    // S1 wins if S0 is absent, or if S0 has already used up its streak allowance
    assign pick_s1      = S1_ARVALID & (~S0_ARVALID | (streak_reg >= STREAK_LIM));
    assign in_data      = (state_reg == DATA);
    assign owner_rready = grant_reg ? S1_RREADY : S0_RREADY;
    assign beat_ok      = in_data & M_AXI_RVALID & owner_rready;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_reg   <= IDLE;
            streak_reg  <= 8'd0;
            araddr_reg  <= 32'd0;
            arlen_reg   <= 8'd0;
            arvalid_reg <= 1'b0;
            grant_reg   <= 1'b0;
            rd_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (S0_ARVALID | S1_ARVALID) begin
                        grant_reg   <= pick_s1;
                        araddr_reg  <= pick_s1 ? S1_ARADDR : S0_ARADDR;
                        arlen_reg   <= pick_s1 ? S1_ARLEN : S0_ARLEN;
                        arvalid_reg <= 1'b1;
                        state_reg   <= ADDR;
                        if (!pick_s1 && S1_ARVALID) begin
                            if (streak_reg != 8'hFF)
                                streak_reg <= streak_reg + 8'd1;
                        end else begin
                            streak_reg <= 8'd0;
                        end
                    end
                end
                ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_reg <= 1'b0;
                        state_reg   <= DATA;
                    end
                end
                DATA: begin
                    if (beat_ok) begin
                        if (M_AXI_RRESP != 2'b00)
                            rd_err_reg <= 1'b1;
                        if (M_AXI_RLAST)
                            state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign M_AXI_ARADDR  = araddr_reg;
    assign M_AXI_ARLEN   = arlen_reg;
    assign M_AXI_ARSIZE  = ARSIZE_V;
    assign M_AXI_ARBURST = ARBURST_V;
    assign M_AXI_ARCACHE = ARCACHE_V;
    assign M_AXI_ARVALID = arvalid_reg;

    assign S0_ARREADY = (state_reg == ADDR) & ~grant_reg & M_AXI_ARREADY;
    assign S1_ARREADY = (state_reg == ADDR) &  grant_reg & M_AXI_ARREADY;

    // Only the handshake is steered; RDATA/RRESP fan out to both requesters outside this block
    assign S0_RVALID    = in_data & ~grant_reg & M_AXI_RVALID;
    assign S1_RVALID    = in_data &  grant_reg & M_AXI_RVALID;
    assign S0_RLAST     = in_data & ~grant_reg & M_AXI_RLAST;
    assign S1_RLAST     = in_data &  grant_reg & M_AXI_RLAST;
    assign M_AXI_RREADY = in_data & owner_rready;

    assign grant  = grant_reg;
    assign busy   = (state_reg != IDLE);
    assign rd_err = rd_err_reg;

endmodule

// File: tb/tb_lcd_axi_rd_arb.sv
// Bench for lcd_axi_rd_arb: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_lcd_axi_rd_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] S0_ARADDR, S1_ARADDR;
    logic [7:0]  S0_ARLEN, S1_ARLEN;
    logic        S0_ARVALID, S1_ARVALID;
    logic        S0_ARREADY, S1_ARREADY;
    logic        S0_RVALID, S1_RVALID, S0_RLAST, S1_RLAST;
    logic        S0_RREADY, S1_RREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic [3:0]  M_AXI_ARCACHE;
    logic        M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RLAST, M_AXI_RREADY;
    logic [1:0]  M_AXI_RRESP;
    logic        grant, busy, rd_err;

    lcd_axi_rd_arb #(.STREAK(4), .ARSIZE_V(3'd2), .ARBURST_V(2'd1), .ARCACHE_V(4'd3)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
        .S0_RVALID(S0_RVALID), .S0_RLAST(S0_RLAST), .S0_RREADY(S0_RREADY),
        .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
        .S1_RVALID(S1_RVALID), .S1_RLAST(S1_RLAST), .S1_RREADY(S1_RREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
        .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARCACHE(M_AXI_ARCACHE),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RREADY(M_AXI_RREADY), .grant(grant), .busy(busy), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst is "pending address" until AR handshake, then "moving data" until RLAST
    int          m_phase;   // 0 no burst, 1 address pending, 2 data moving
    int          m_owner;
    int          m_run;     // S0 wins in a row while S1 was waiting
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    bit          m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_owner <= 0; m_run <= 0; m_addr <= 0; m_len <= 0; m_err <= 0;
        end else if (m_phase == 0) begin
            if (S0_ARVALID || S1_ARVALID) begin
                int w;
                w = (S1_ARVALID && (!S0_ARVALID || m_run >= 4)) ? 1 : 0;
                m_owner <= w;
                m_addr  <= w ? S1_ARADDR : S0_ARADDR;
                m_len   <= w ? S1_ARLEN : S0_ARLEN;
                m_run   <= (w == 0 && S1_ARVALID) ? ((m_run + 1 > 255) ? 255 : m_run + 1) : 0;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            if (M_AXI_ARREADY) m_phase <= 2;
        end else begin
            if (M_AXI_RVALID && (m_owner ? S1_RREADY : S0_RREADY)) begin
                if (M_AXI_RRESP != 2'b00) m_err <= 1;
                if (M_AXI_RLAST) m_phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        logic data_ph;
        data_ph = (m_phase == 2);
        chk("arvalid", M_AXI_ARVALID, m_phase == 1);
        if (m_phase == 1) begin
            chk("araddr", M_AXI_ARADDR, m_addr);
            chk("arlen", M_AXI_ARLEN, m_len);
        end
        chk("grant", grant, m_owner);
        chk("busy", busy, m_phase != 0);
        chk("rd_err", rd_err, m_err);
        chk("s0_arready", S0_ARREADY, m_phase == 1 && m_owner == 0 && M_AXI_ARREADY);
        chk("s1_arready", S1_ARREADY, m_phase == 1 && m_owner == 1 && M_AXI_ARREADY);
        chk("s0_rvalid", S0_RVALID, data_ph && m_owner == 0 && M_AXI_RVALID);
        chk("s1_rvalid", S1_RVALID, data_ph && m_owner == 1 && M_AXI_RVALID);
        chk("s0_rlast", S0_RLAST, data_ph && m_owner == 0 && M_AXI_RLAST);
        chk("s1_rlast", S1_RLAST, data_ph && m_owner == 1 && M_AXI_RLAST);
        chk("m_rready", M_AXI_RREADY, data_ph && (m_owner ? S1_RREADY : S0_RREADY));
        chk("ar_consts", {M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE}, {3'd2, 2'd1, 4'd3});
    end

    // Event counters and AR log for the directed checks
    int          s0_beats = 0, s1_beats = 0, s0_lasts = 0, s0_last_pos = 0;
    int          arv_cyc = 0, s0_arr = 0;
    logic        glog[$];
    logic [31:0] alog[$];
    logic [7:0]  llog[$];

    always @(posedge clk) begin
        if (S0_RVALID && S0_RREADY) begin
            s0_beats <= s0_beats + 1;
            if (S0_RLAST) begin
                s0_lasts    <= s0_lasts + 1;
                s0_last_pos <= s0_beats + 1;
            end
        end
        if (S1_RVALID && S1_RREADY) s1_beats <= s1_beats + 1;
        if (M_AXI_ARVALID) arv_cyc <= arv_cyc + 1;
        if (S0_ARREADY) s0_arr <= s0_arr + 1;
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            glog.push_back(grant);
            alog.push_back(M_AXI_ARADDR);
            llog.push_back(M_AXI_ARLEN);
        end
    end

    // Requester stimulus state
    int          s0_pending = 0, s1_pending = 0, s0_idx = 0, s1_idx = 0;
    logic [31:0] s0_base = 32'h1000_0000, s1_base = 32'h2000_0000;
    logic [7:0]  s0_len = 8'd0, s1_len = 8'd0;

    task automatic set_reqs();
        S0_ARVALID = (s0_pending > 0);
        S0_ARADDR  = s0_base + 32'(s0_idx) * 32'h100;
        S0_ARLEN   = s0_len;
        S1_ARVALID = (s1_pending > 0);
        S1_ARADDR  = s1_base + 32'(s1_idx) * 32'h40;
        S1_ARLEN   = s1_len;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Acts as the AXI slave for one burst; abort_at>=0 asserts reset before that beat
    task automatic serve(input int ar_wait, input int nbeats, input logic [1:0] resp,
                         input bit toggle, input int abort_at);
        int n;
        int own;
        bit tog;
        bit rdy;
        n = 0;
        while (!M_AXI_ARVALID && n < 50) begin tick(); n++; end
        if (!M_AXI_ARVALID) begin
            total++; bad++;
            $display("FAIL ar_timeout actual=0 required=1 at %0t", $time);
            return;
        end
        repeat (ar_wait) tick();
        M_AXI_ARREADY = 1'b1;
        own = m_owner;
        tick();
        M_AXI_ARREADY = 1'b0;
        if (own == 0) begin s0_pending--; s0_idx++; end
        else begin s1_pending--; s1_idx++; end
        set_reqs();
        tog = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            if (b == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_arvalid", M_AXI_ARVALID, 1'b0);
                chk("rst_rready", M_AXI_RREADY, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_grant", grant, 1'b0);
                M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
                return;
            end
            M_AXI_RVALID = 1'b1;
            M_AXI_RLAST  = (b == nbeats - 1);
            M_AXI_RRESP  = resp;
            n = 0;
            do begin
                rdy = toggle ? tog : 1'b1;
                tog = ~tog;
                S0_RREADY = (own == 0) ? rdy : ~rdy;
                S1_RREADY = (own == 1) ? rdy : ~rdy;
                tick();
                n++;
            end while (!rdy && n < 10);
        end
        M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = 2'b00;
        S0_RREADY = 1'b0; S1_RREADY = 1'b0;
    endtask

    localparam logic GSEQ [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        int b0, b1, a0, r0, g0, l0;
        rst_n = 1'b0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RLAST = 0; M_AXI_RRESP = 0;
        S0_RREADY = 0; S1_RREADY = 0;
        set_reqs();
        repeat (3) tick();
        chk("reset_arvalid", M_AXI_ARVALID, 1'b0);
        chk("reset_araddr", M_AXI_ARADDR, 32'h0);
        chk("reset_arlen", M_AXI_ARLEN, 8'h0);
        chk("reset_grant", grant, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rd_err", rd_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // S0 alone, 20 beats, AR accepted after 2 wait cycles
        b0 = s0_beats; b1 = s1_beats; a0 = arv_cyc; r0 = s0_arr; l0 = s0_lasts;
        s0_len = 8'd19; s0_pending = 1; set_reqs();
        serve(2, 20, 2'b00, 0, -1);
        chk("t1_araddr", alog[alog.size()-1], 32'h1000_0000);
        chk("t1_arlen", llog[llog.size()-1], 8'd19);
        chk("t1_arvalid_cycles", arv_cyc - a0, 3);
        chk("t1_s0_arready_pulses", s0_arr - r0, 1);
        chk("t1_s0_beats", s0_beats - b0, 20);
        chk("t1_s0_rlast_count", s0_lasts - l0, 1);
        chk("t1_rlast_on_beat", s0_last_pos - b0, 20);
        chk("t1_s1_beats", s1_beats - b1, 0);
        @(negedge clk);
        chk("t1_busy_after", busy, 1'b0);
        tick();

        // Stray RVALID while idle must not be steered or accepted
        M_AXI_RVALID = 1'b1; S0_RREADY = 1'b1; S1_RREADY = 1'b1;
        #1;
        chk("t6_rready", M_AXI_RREADY, 1'b0);
        chk("t6_rvalids", {S0_RVALID, S1_RVALID}, 2'b00);
        tick();
        M_AXI_RVALID = 1'b0; S0_RREADY = 1'b0; S1_RREADY = 1'b0;
        chk("t6_busy", busy, 1'b0);

        // Both requesters held valid: S1 forced in after four S0 grants
        g0 = glog.size();
        s0_len = 8'd1; s1_len = 8'd5; s0_pending = 8; s1_pending = 2; set_reqs();
        for (int i = 0; i < 10; i++) serve(0, 2, 2'b00, 0, -1);
        for (int i = 0; i < 10; i++) chk($sformatf("t2_grant%0d", i), glog[g0+i], GSEQ[i]);
        chk("t2_s1_addr_a", alog[g0+4], 32'h2000_0000);
        chk("t2_s1_addr_b", alog[g0+9], 32'h2000_0040);
        chk("t2_s1_len", llog[g0+4], 8'd5);

        // S1 single beat with SLVERR: sticky error
        b1 = s1_beats;
        s1_base = 32'h3000_0000; s1_idx = 0; s1_len = 8'd0; s1_pending = 1; set_reqs();
        serve(1, 1, 2'b10, 0, -1);
        chk("t3_s1_beats", s1_beats - b1, 1);
        chk("t3_rd_err", rd_err, 1'b1);

        // Backpressure on S0 during an 8-beat burst
        b0 = s0_beats;
        s0_len = 8'd7; s0_pending = 1; set_reqs();
        serve(0, 8, 2'b00, 1, -1);
        chk("t4_s0_beats", s0_beats - b0, 8);
        chk("t4_rd_err_sticky", rd_err, 1'b1);

        // Reset asserted mid-burst (S1 owner, beat 5 of 20)
        s1_len = 8'd19; s1_pending = 1; set_reqs();
        serve(0, 20, 2'b00, 0, 5);
        s0_pending = 0; s1_pending = 0; set_reqs();
        S0_RREADY = 1'b0; S1_RREADY = 1'b0;
        repeat (2) tick();
        @(posedge clk); #3 rst_n = 1'b1;
        tick();
        chk("t5_rd_err_cleared", rd_err, 1'b0);
        b0 = s0_beats;
        s0_base = 32'h4000_0000; s0_idx = 0; s0_len = 8'd3; s0_pending = 1; set_reqs();
        serve(1, 4, 2'b00, 0, -1);
        chk("t5_fresh_addr", alog[alog.size()-1], 32'h4000_0000);
        chk("t5_fresh_grant", glog[glog.size()-1], 1'b0);
        chk("t5_fresh_beats", s0_beats - b0, 4);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
